// File: rtl/mc_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes, ALU control codes
// and FSM state encoding. MC_IMMLOGIC_EN adds the andi/ori execute states.
package mc_controller_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctSlt = 6'h2A;

  // Bit 5 inverts operand b with carry-in 1; [4:0] selects the operation.
  localparam logic [5:0] AluAnd = 6'b000000;
  localparam logic [5:0] AluOr  = 6'b000001;
  localparam logic [5:0] AluAdd = 6'b000010;
  localparam logic [5:0] AluSub = 6'b100010;
  localparam logic [5:0] AluSlt = 6'b100011;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
`ifdef MC_IMMLOGIC_EN
    ,
    StAndiEx  = 4'd12,
    StOriEx   = 4'd13
`endif
  } state_e;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// R-type funct to ALU control decoder; purely combinational so the pipelined core can reuse it.
module mc_controller_alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [5:0] alucont_o,
  output logic       valid_o
);

  always_comb begin
    alucont_o = AluAdd;
    valid_o   = 1'b1;
    case (funct_i)
      FunctAdd: alucont_o = AluAdd;
      FunctSub: alucont_o = AluSub;
      FunctAnd: alucont_o = AluAnd;
      FunctOr:  alucont_o = AluOr;
      FunctSlt: alucont_o = AluSlt;
      default:  valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic and Moore output decode.
// Define MC_IMMLOGIC_EN to support andi (0C) and ori (0D); otherwise they decode as illegal.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [5:0] alucont_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic       iord_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       regwrite_o,
  output logic [1:0] pcsrc_o,
  output logic       pcen_o,
  output logic       illegal_o
);

  state_e     state_q, state_d;
  logic [5:0] dec_alucont;
  logic       dec_valid;
  logic       pcwrite, branch, memwrite, irwrite, regwrite, illegal;

  mc_controller_alu_decoder u_alu_decoder (
    .funct_i   (funct_i),
    .alucont_o (dec_alucont),
    .valid_o   (dec_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (op_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
`ifdef MC_IMMLOGIC_EN
          OpAndi:     state_d = StAndiEx;
          OpOri:      state_d = StOriEx;
`endif
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        if (op_i == OpLw) begin
          state_d = StMemRd;
        end else if (op_i == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd:   if (mem_ready_i) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ready_i) state_d = StFetch;
      StRtypeEx: state_d = dec_valid ? StRtypeWb : StFetch;
      StRtypeWb: state_d = StFetch;
      StBeqEx:   state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJEx:     state_d = StFetch;
`ifdef MC_IMMLOGIC_EN
      StAndiEx:  state_d = StAddiWb;
      StOriEx:   state_d = StAddiWb;
`endif
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    alucont_o  = AluAdd;
    alusrca_o  = 1'b0;
    alusrcb_o  = 2'b00;
    iord_o     = 1'b0;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    pcsrc_o    = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb_o = 2'b01;
        irwrite   = mem_ready_i;
        pcwrite   = mem_ready_i;
      end
      StDecode: begin
        alusrcb_o = 2'b11;
        case (op_i)
          OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: illegal = 1'b0;
`ifdef MC_IMMLOGIC_EN
          OpAndi, OpOri:                           illegal = 1'b0;
`endif
          default:                                 illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
      end
      StMemRd:   iord_o = 1'b1;
      StMemWb: begin
        memtoreg_o = 1'b1;
        regwrite   = 1'b1;
      end
      StMemWr: begin
        iord_o   = 1'b1;
        memwrite = 1'b1;
      end
      StRtypeEx: begin
        alusrca_o = 1'b1;
        alucont_o = dec_alucont;
        illegal   = ~dec_valid;
      end
      StRtypeWb: begin
        regdst_o = 1'b1;
        regwrite = 1'b1;
      end
      StBeqEx: begin
        alusrca_o = 1'b1;
        alucont_o = AluSub;
        pcsrc_o   = 2'b01;
        branch    = 1'b1;
      end
      StAddiEx: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
      end
      StAddiWb:  regwrite = 1'b1;
      StJEx: begin
        pcsrc_o = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_IMMLOGIC_EN
      StAndiEx: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        alucont_o = AluAnd;
      end
      StOriEx: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        alucont_o = AluOr;
      end
`endif
      default:   illegal = 1'b1;
    endcase
  end

  // Reset masks every side-effecting strobe so nothing is written while reset is held.
  assign memwrite_o = memwrite & rst_ni;
  assign irwrite_o  = irwrite & rst_ni;
  assign regwrite_o = regwrite & rst_ni;
  assign pcen_o     = (pcwrite | (branch & zero_i)) & rst_ni;
  assign illegal_o  = illegal & rst_ni;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: table of per-cycle vectors plus reset sequences.
module tb_mc_controller;

  typedef struct packed {
    logic [5:0] alucont;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } outv_t;

  typedef struct packed {
    outv_t e;
    outv_t c;
  } exp_t;

  typedef struct {
    string      name;
    logic       mr;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    outv_t      e;
    outv_t      c;
  } vec_t;

  logic       clk, rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic [5:0] alucont;
  logic       alusrca, iord, memwrite, irwrite, regdst, memtoreg, regwrite, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  outv_t      act;
  int         n_cmp, n_fail;
  vec_t       tbl[$];

  mc_controller dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .op_i        (op),
    .funct_i     (funct),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .alucont_o   (alucont),
    .alusrca_o   (alusrca),
    .alusrcb_o   (alusrcb),
    .iord_o      (iord),
    .memwrite_o  (memwrite),
    .irwrite_o   (irwrite),
    .regdst_o    (regdst),
    .memtoreg_o  (memtoreg),
    .regwrite_o  (regwrite),
    .pcsrc_o     (pcsrc),
    .pcen_o      (pcen),
    .illegal_o   (illegal)
  );

  assign act = {alucont, alusrca, alusrcb, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                pcsrc, pcen, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs per state; only selects the state defines are marked as cared.
  function automatic exp_t base();
    exp_t x;
    x.e = '0;
    x.c = '0;
    x.e.alucont = 6'b000010;
    x.c.alucont = '1;
    x.c.memwrite = 1'b1;
    x.c.irwrite = 1'b1;
    x.c.regwrite = 1'b1;
    x.c.pcen = 1'b1;
    x.c.illegal = 1'b1;
    return x;
  endfunction

  function automatic exp_t e_fetch(logic mr);
    exp_t x = base();
    x.c.iord = 1'b1;
    x.c.alusrca = 1'b1;
    x.e.alusrcb = 2'b01; x.c.alusrcb = '1;
    x.c.pcsrc = '1;
    x.e.irwrite = mr;
    x.e.pcen = mr;
    return x;
  endfunction

  function automatic exp_t e_decode(logic ill);
    exp_t x = base();
    x.c.alusrca = 1'b1;
    x.e.alusrcb = 2'b11; x.c.alusrcb = '1;
    x.e.illegal = ill;
    return x;
  endfunction

  function automatic exp_t e_imm_ex(logic [5:0] alu);
    exp_t x = base();
    x.e.alusrca = 1'b1; x.c.alusrca = 1'b1;
    x.e.alusrcb = 2'b10; x.c.alusrcb = '1;
    x.e.alucont = alu;
    return x;
  endfunction

  function automatic exp_t e_mem(logic wr);
    exp_t x = base();
    x.e.iord = 1'b1; x.c.iord = 1'b1;
    x.e.memwrite = wr;
    return x;
  endfunction

  function automatic exp_t e_wb(logic rd, logic m2r);
    exp_t x = base();
    x.e.regdst = rd; x.c.regdst = 1'b1;
    x.e.memtoreg = m2r; x.c.memtoreg = 1'b1;
    x.e.regwrite = 1'b1;
    return x;
  endfunction

  function automatic exp_t e_rtex(logic [5:0] alu, logic ill);
    exp_t x = base();
    x.e.alusrca = 1'b1; x.c.alusrca = 1'b1;
    x.c.alusrcb = '1;
    if (ill) begin
      x.c.alucont = '0;
      x.e.illegal = 1'b1;
    end else begin
      x.e.alucont = alu;
    end
    return x;
  endfunction

  function automatic exp_t e_beq(logic z);
    exp_t x = base();
    x.e.alusrca = 1'b1; x.c.alusrca = 1'b1;
    x.c.alusrcb = '1;
    x.e.alucont = 6'b100010;
    x.e.pcsrc = 2'b01; x.c.pcsrc = '1;
    x.e.pcen = z;
    return x;
  endfunction

  function automatic exp_t e_jex();
    exp_t x = base();
    x.e.pcsrc = 2'b10; x.c.pcsrc = '1;
    x.e.pcen = 1'b1;
    return x;
  endfunction

  task automatic add(input string n, input logic mr, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input exp_t x);
    vec_t v;
    v.name = n; v.mr = mr; v.op = o; v.funct = f; v.zero = z; v.e = x.e; v.c = x.c;
    tbl.push_back(v);
  endtask

  task automatic check(input string n, input outv_t e, input outv_t c);
    n_cmp++;
    if (((act ^ e) & c) != '0) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h (care mask %05h)", n, act, e, c);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    mem_ready = v.mr; op = v.op; funct = v.funct; zero = v.zero;
    #1;
    check(v.name, v.e, v.c);
  endtask

  task automatic step(input string n, input logic mr, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input exp_t x);
    vec_t v;
    v.name = n; v.mr = mr; v.op = o; v.funct = f; v.zero = z; v.e = x.e; v.c = x.c;
    apply(v);
  endtask

  task automatic add_rtype(input string n, input logic [5:0] f, input logic [5:0] alu);
    add({n, "_fetch"}, 1'b1, 6'h00, f, 1'b0, e_fetch(1'b1));
    add({n, "_decode"}, 1'b1, 6'h00, f, 1'b0, e_decode(1'b0));
    add({n, "_ex"}, 1'b1, 6'h00, f, 1'b0, e_rtex(alu, 1'b0));
    add({n, "_wb"}, 1'b1, 6'h00, f, 1'b0, e_wb(1'b1, 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    // lw, no stalls: 5 cycles, write-back only in the last.
    add("lw_fetch", 1'b1, 6'h23, 6'h00, 1'b0, e_fetch(1'b1));
    add("lw_decode", 1'b1, 6'h23, 6'h00, 1'b1, e_decode(1'b0));
    add("lw_memadr", 1'b1, 6'h23, 6'h00, 1'b0, e_imm_ex(6'b000010));
    add("lw_memrd", 1'b1, 6'h23, 6'h00, 1'b0, e_mem(1'b0));
    add("lw_memwb", 1'b1, 6'h23, 6'h00, 1'b0, e_wb(1'b0, 1'b1));
    // sw with a 3-cycle fetch stall and a 2-cycle write stall.
    add("sw_fetch_stall0", 1'b0, 6'h2B, 6'h00, 1'b0, e_fetch(1'b0));
    add("sw_fetch_stall1", 1'b0, 6'h2B, 6'h00, 1'b0, e_fetch(1'b0));
    add("sw_fetch_stall2", 1'b0, 6'h2B, 6'h00, 1'b0, e_fetch(1'b0));
    add("sw_fetch_ready", 1'b1, 6'h2B, 6'h00, 1'b0, e_fetch(1'b1));
    add("sw_decode", 1'b1, 6'h2B, 6'h00, 1'b0, e_decode(1'b0));
    add("sw_memadr", 1'b1, 6'h2B, 6'h00, 1'b0, e_imm_ex(6'b000010));
    add("sw_memwr_wait0", 1'b0, 6'h2B, 6'h00, 1'b0, e_mem(1'b1));
    add("sw_memwr_wait1", 1'b0, 6'h2B, 6'h00, 1'b0, e_mem(1'b1));
    add("sw_memwr_ready", 1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1));
    // R-type functions.
    add_rtype("r_sub", 6'h22, 6'b100010);
    add_rtype("r_add", 6'h20, 6'b000010);
    add_rtype("r_and", 6'h24, 6'b000000);
    add_rtype("r_or", 6'h25, 6'b000001);
    add_rtype("r_slt", 6'h2A, 6'b100011);
    add("r_bad_fetch", 1'b1, 6'h00, 6'h3F, 1'b0, e_fetch(1'b1));
    add("r_bad_decode", 1'b1, 6'h00, 6'h3F, 1'b0, e_decode(1'b0));
    add("r_bad_ex", 1'b1, 6'h00, 6'h3F, 1'b0, e_rtex(6'b000000, 1'b1));
    // beq taken / not taken.
    add("beq_t_fetch", 1'b1, 6'h04, 6'h00, 1'b1, e_fetch(1'b1));
    add("beq_t_decode", 1'b1, 6'h04, 6'h00, 1'b1, e_decode(1'b0));
    add("beq_t_ex", 1'b1, 6'h04, 6'h00, 1'b1, e_beq(1'b1));
    add("beq_n_fetch", 1'b1, 6'h04, 6'h00, 1'b0, e_fetch(1'b1));
    add("beq_n_decode", 1'b1, 6'h04, 6'h00, 1'b0, e_decode(1'b0));
    add("beq_n_ex", 1'b1, 6'h04, 6'h00, 1'b0, e_beq(1'b0));
    // addi and j.
    add("addi_fetch", 1'b1, 6'h08, 6'h00, 1'b0, e_fetch(1'b1));
    add("addi_decode", 1'b1, 6'h08, 6'h00, 1'b0, e_decode(1'b0));
    add("addi_ex", 1'b1, 6'h08, 6'h00, 1'b0, e_imm_ex(6'b000010));
    add("addi_wb", 1'b1, 6'h08, 6'h00, 1'b0, e_wb(1'b0, 1'b0));
    add("j_fetch", 1'b1, 6'h02, 6'h00, 1'b0, e_fetch(1'b1));
    add("j_decode", 1'b1, 6'h02, 6'h00, 1'b0, e_decode(1'b0));
    add("j_ex", 1'b1, 6'h02, 6'h00, 1'b0, e_jex());
    // ori: new states when enabled, illegal at decode otherwise.
    add("ori_fetch", 1'b1, 6'h0D, 6'h00, 1'b0, e_fetch(1'b1));
`ifdef MC_IMMLOGIC_EN
    add("ori_decode", 1'b1, 6'h0D, 6'h00, 1'b0, e_decode(1'b0));
    add("ori_ex", 1'b1, 6'h0D, 6'h00, 1'b0, e_imm_ex(6'b000001));
    add("ori_wb", 1'b1, 6'h0D, 6'h00, 1'b0, e_wb(1'b0, 1'b0));
    add("andi_fetch", 1'b1, 6'h0C, 6'h00, 1'b0, e_fetch(1'b1));
    add("andi_decode", 1'b1, 6'h0C, 6'h00, 1'b0, e_decode(1'b0));
    add("andi_ex", 1'b1, 6'h0C, 6'h00, 1'b0, e_imm_ex(6'b000000));
    add("andi_wb", 1'b1, 6'h0C, 6'h00, 1'b0, e_wb(1'b0, 1'b0));
`else
    add("ori_decode_illegal", 1'b1, 6'h0D, 6'h00, 1'b0, e_decode(1'b1));
    add("andi_fetch", 1'b1, 6'h0C, 6'h00, 1'b0, e_fetch(1'b1));
    add("andi_decode_illegal", 1'b1, 6'h0C, 6'h00, 1'b0, e_decode(1'b1));
`endif
    add("back_to_fetch", 1'b0, 6'h00, 6'h00, 1'b0, e_fetch(1'b0));

    // Reset held with mem_ready high: every strobe must stay low.
    repeat (2) @(negedge clk);
    #1;
    x = e_fetch(1'b0);
    check("reset_hold", x.e, x.c);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted mid-MEMWR: memwrite drops in the same cycle, FETCH resumes after release.
    step("rst_sw_fetch", 1'b1, 6'h2B, 6'h00, 1'b0, e_fetch(1'b1));
    step("rst_sw_decode", 1'b1, 6'h2B, 6'h00, 1'b0, e_decode(1'b0));
    step("rst_sw_memadr", 1'b1, 6'h2B, 6'h00, 1'b0, e_imm_ex(6'b000010));
    step("rst_sw_memwr", 1'b0, 6'h2B, 6'h00, 1'b0, e_mem(1'b1));
    @(negedge clk);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    x = e_fetch(1'b0);
    check("rst_mid_memwr", x.e, x.c);
    @(negedge clk);
    #1;
    check("rst_mid_memwr_held", x.e, x.c);
    rst_n = 1'b1;
    #1;
    x = e_fetch(1'b1);
    check("rst_release_fetch", x.e, x.c);
    step("rst_after_decode", 1'b1, 6'h2B, 6'h00, 1'b0, e_decode(1'b0));
    step("rst_after_memadr", 1'b1, 6'h2B, 6'h00, 1'b0, e_imm_ex(6'b000010));
    step("rst_after_memwr", 1'b1, 6'h2B, 6'h00, 1'b0, e_mem(1'b1));
    step("rst_after_fetch", 1'b1, 6'h00, 6'h00, 1'b0, e_fetch(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
